// File: rtl/panel_input.sv
// panel_input: synchronizes and debounces the push button and DIP switches, emits press/release/change pulses,
// latches the DIP value on each press and generates a slow step enable. Define PANEL_LONG_PRESS_EN for pb_long.
module panel_input #(
    parameter int DB_CYCLES   = 540000,
    parameter int TICK_N      = 27000000,
    parameter int LONG_CYCLES = 54000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb,
    input  logic [3:0] DIP,
    output logic       pb_level,
    output logic       pb_press,
    output logic       pb_release,
    output logic [3:0] dip_q,
    output logic       dip_chg,
    output logic [3:0] dip_latch,
    output logic       tick,
    output logic       pb_long
);

    localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam int TW = (TICK_N > 2) ? $clog2(TICK_N) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_N - 1);

    if (DB_CYCLES < 2) begin : g_db_check
        $error("DB_CYCLES must be at least 2");
    end
    if (TICK_N < 2) begin : g_tick_check
        $error("TICK_N must be at least 2");
    end
    if (LONG_CYCLES < 1) begin : g_long_check
        $error("LONG_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        UP,
        WAIT_DN,
        DOWN,
        WAIT_UP
    } btn_state_t;

    logic             pb_s1;
    logic             pb_s2;
    logic [3:0]       dip_s1;
    logic [3:0]       dip_s2;
    logic [3:0]       dip_prev;
    logic [DBW-1:0]   dip_cnt;
    logic [DBW-1:0]   db_cnt;
    logic [TW-1:0]    tick_cnt;
    logic [TW-1:0]    tick_cnt_next;
    btn_state_t       state;
    logic             press_now;
    logic             dip_load;

    // Button resyncs as released, DIP as all-zero, so a held button after reset is a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pb_s1  <= 1'b1;
            pb_s2  <= 1'b1;
            dip_s1 <= '0;
            dip_s2 <= '0;
        end else begin
            pb_s1  <= pb;
            pb_s2  <= pb_s1;
            dip_s1 <= DIP;
            dip_s2 <= dip_s1;
        end
    end

    assign press_now = (state == WAIT_DN) && !pb_s2 && (db_cnt == DB_LAST);
    assign dip_load  = (dip_s2 == dip_prev) && (dip_cnt == DB_LAST) && (dip_s2 != dip_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= UP;
            db_cnt     <= '0;
            pb_level   <= 1'b0;
            pb_press   <= 1'b0;
            pb_release <= 1'b0;
        end else begin
            pb_press   <= 1'b0;
            pb_release <= 1'b0;
            case (state)
                UP: begin
                    if (!pb_s2) begin
                        state  <= WAIT_DN;
                        db_cnt <= '0;
                    end
                end
                WAIT_DN: begin
                    if (pb_s2) begin
                        state  <= UP;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state    <= DOWN;
                        db_cnt   <= '0;
                        pb_press <= 1'b1;
                        pb_level <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DBW'(1);
                    end
                end
                DOWN: begin
                    if (pb_s2) begin
                        state  <= WAIT_UP;
                        db_cnt <= '0;
                    end
                end
                WAIT_UP: begin
                    if (!pb_s2) begin
                        state  <= DOWN;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state      <= UP;
                        db_cnt     <= '0;
                        pb_release <= 1'b1;
                        pb_level   <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DBW'(1);
                    end
                end
                default: begin
                    state  <= UP;
                    db_cnt <= '0;
                end
            endcase
        end
    end

    // Stability counter saturates; a commit only happens when the settled vector differs from dip_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dip_prev <= '0;
            dip_cnt  <= '0;
            dip_q    <= '0;
            dip_chg  <= 1'b0;
        end else begin
            dip_prev <= dip_s2;
            dip_chg  <= 1'b0;
            if (dip_s2 != dip_prev) begin
                dip_cnt <= '0;
            end else if (dip_cnt == DB_LAST) begin
                if (dip_load) begin
                    dip_q   <= dip_s2;
                    dip_chg <= 1'b1;
                end
            end else begin
                dip_cnt <= dip_cnt + DBW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dip_latch <= '0;
        end else if (press_now) begin
            dip_latch <= dip_load ? dip_s2 : dip_q;
        end
    end

    // Counter restarts the cycle after a press, so the first tick lands TICK_N cycles after pb_press.
    assign tick_cnt_next = pb_press                ? '0 :
                           (tick_cnt == TICK_LAST) ? '0 :
                                                     tick_cnt + TW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt_next;
            tick     <= (tick_cnt_next == TICK_LAST) && !press_now;
        end
    end

`ifdef PANEL_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_FULL = LW'(LONG_CYCLES);

    logic [LW-1:0] hold_cnt;

    // Hold time pauses during a release bounce and saturates after the single pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            pb_long  <= 1'b0;
        end else begin
            pb_long <= 1'b0;
            if (press_now) begin
                hold_cnt <= '0;
            end else if (state == DOWN) begin
                if (hold_cnt == LONG_LAST) begin
                    hold_cnt <= LONG_FULL;
                    pb_long  <= 1'b1;
                end else if (hold_cnt != LONG_FULL) begin
                    hold_cnt <= hold_cnt + LW'(1);
                end
            end else if (state == UP || state == WAIT_DN) begin
                hold_cnt <= '0;
            end
        end
    end
`else
    assign pb_long = 1'b0;
`endif

endmodule
